sprite_compositor: RTL and testbench

- Downstream of the per-sprite renderers. Each renderer produces a `color` value and an `is_display` flag.
- Merges up to N sprite layers plus a background colour into the single 12-bit RGB pixel driven to the VGA pins.
- Realigns each renderer's combinational `is_display` with its one-cycle-registered `color`, resolves priority and colour-key transparency, and blanks outside the active region.
- Also reports per-frame sticky collisions between layer 0 (player) and every other layer.

---
 rtl/sprite_compositor_pkg.sv | 30 +++
 rtl/sprite_compositor_prio_select.sv | 30 +++
 rtl/sprite_compositor.sv | 79 +++++++
 tb/tb_sprite_compositor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor_pkg
//  Purpose  : Shared constants and helpers for the sprite compositing path.
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_compositor_pkg;

   typedef logic [15:0] rgb565_t;
   typedef logic [11:0] rgb444_t;

   localparam rgb565_t TRANSPARENT_KEY = 16'hFFFF;

   // Top four bits of each RGB565 channel feed the 4-bit VGA DACs.
   localparam int R_HI = 15;
   localparam int R_LO = 12;
   localparam int G_HI = 10;
   localparam int G_LO = 7;
   localparam int B_HI = 4;
   localparam int B_LO = 1;

   // Clocks from (x,y) to rgb_out; anything aligning with the pixel uses this.
   localparam int PIX_LAT = 2;

   function automatic rgb444_t rgb565_to_444(input rgb565_t c);
      return {c[R_HI:R_LO], c[G_HI:G_LO], c[B_HI:B_LO]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_compositor_prio_select.sv
`default_nettype none
// ============================================================================
//  Module   : prio_select
//  Purpose  : Combinational layer priority mux; lowest opaque index wins,
//             background otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_select
   import sprite_compositor_pkg::*;
#(
   parameter int N_LAYERS = 4
) (
   input  logic [N_LAYERS-1:0]    opaque,
   input  logic [16*N_LAYERS-1:0] colors,
   input  rgb565_t                bg_color,
   output rgb565_t                sel_color
);

   // Walk from the lowest priority upward so the smallest index overwrites last.
   always_comb begin
      sel_color = bg_color;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (opaque[i]) begin
            sel_color = colors[16*i +: 16];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Merges sprite layers and background into the VGA pixel and
//             reports per-frame player collisions.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor
   import sprite_compositor_pkg::*;
#(
   parameter int      N_LAYERS    = 4,
   parameter rgb565_t TRANSPARENT = TRANSPARENT_KEY
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [9:0]              x,
   input  logic [8:0]              y,
   input  logic                    video_on,
   input  logic [N_LAYERS-1:0]     layer_disp,
   input  logic [16*N_LAYERS-1:0]  layer_color,
   input  rgb565_t                 bg_color,
   output rgb444_t                 rgb_out,
   output logic [N_LAYERS-1:0]     collide,
   output logic                    collide_valid
);

   logic [N_LAYERS-1:0] r_disp_a;
   logic                r_von_a;
   logic                r_sof_a;
   logic [N_LAYERS-1:0] r_acc;
   logic [N_LAYERS-1:0] w_opaque;
   logic [N_LAYERS-1:0] w_hit;
   rgb565_t             w_sel;

   // layer_color is already one cycle late, so it lines up with r_disp_a.
   for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
      assign w_opaque[gi] = r_disp_a[gi] && (layer_color[16*gi +: 16] != TRANSPARENT);
   end

   assign w_hit = w_opaque[0] ? {w_opaque[N_LAYERS-1:1], 1'b0} : '0;

   prio_select #(
      .N_LAYERS (N_LAYERS)
   ) u_prio_select (
      .opaque    (w_opaque),
      .colors    (layer_color),
      .bg_color  (bg_color),
      .sel_color (w_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_disp_a      <= '0;
         r_von_a       <= 1'b0;
         r_sof_a       <= 1'b0;
         r_acc         <= '0;
         rgb_out       <= '0;
         collide       <= '0;
         collide_valid <= 1'b0;
      end else begin
         r_disp_a <= layer_disp;
         r_von_a  <= video_on;
         r_sof_a  <= (x == 10'd0) && (y == 9'd0);
         rgb_out  <= r_von_a ? rgb565_to_444(w_sel) : 12'h000;

         // The (0,0) pixel closes the old frame and seeds the new one.
         if (r_sof_a) begin
            collide       <= r_acc;
            r_acc         <= w_hit;
            collide_valid <= 1'b1;
         end else begin
            r_acc         <= r_acc | w_hit;
            collide_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sprite_compositor
//  Purpose  : Self-checking bench for sprite_compositor against a pixel-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor;
   import sprite_compositor_pkg::*;

   localparam int N  = 4;
   localparam int FW = 12;
   localparam int FH = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [9:0]      x;
   logic [8:0]      y;
   logic            video_on;
   logic [N-1:0]    layer_disp;
   logic [16*N-1:0] layer_color;
   logic [15:0]     bg_color;
   logic [11:0]     rgb_out;
   logic [N-1:0]    collide;
   logic            collide_valid;

   always #5 clk = ~clk;

   sprite_compositor #(
      .N_LAYERS    (N),
      .TRANSPARENT (16'hFFFF)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .x             (x),
      .y             (y),
      .video_on      (video_on),
      .layer_disp    (layer_disp),
      .layer_color   (layer_color),
      .bg_color      (bg_color),
      .rgb_out       (rgb_out),
      .collide       (collide),
      .collide_valid (collide_valid)
   );

   typedef struct packed {
      logic [11:0]  rgb;
      logic         vld;
      logic [N-1:0] col;
   } exp_t;

   exp_t            exp_q[$];
   int              n_cmp = 0;
   int              n_err = 0;
   int              step;
   logic            p_have;
   logic            p_von;
   logic            p_sof;
   logic [N-1:0]    p_disp;
   logic [16*N-1:0] p_col;
   logic [N-1:0]    m_acc;
   logic [N-1:0]    m_collide;
   logic [15:0]     next_bg;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: first visible non-keyed layer, else background, then channel MSBs.
   task automatic model_push();
      logic [15:0]  c;
      logic [N-1:0] op;
      logic [N-1:0] hit;
      logic         found;
      exp_t         e;
      c     = bg_color;
      found = 1'b0;
      op    = '0;
      for (int i = 0; i < N; i++) begin
         op[i] = p_disp[i] && (p_col[16*i +: 16] !== 16'hFFFF);
         if (op[i] && !found) begin
            c     = p_col[16*i +: 16];
            found = 1'b1;
         end
      end
      e.rgb = p_von ? 12'((((c >> 12) & 16'hF) << 8) | (((c >> 7) & 16'hF) << 4) | ((c >> 1) & 16'hF))
                    : 12'h000;
      hit = '0;
      for (int i = 1; i < N; i++) hit[i] = op[0] && op[i];
      if (p_sof) begin
         m_collide = m_acc;
         m_acc     = hit;
         e.vld     = 1'b1;
      end else begin
         m_acc = m_acc | hit;
         e.vld = 1'b0;
      end
      e.col = m_collide;
      exp_q.push_back(e);
   endtask

   task automatic step_pixel(input logic [9:0] nx, input logic [8:0] ny, input logic nvon,
                             input logic [N-1:0] ndisp, input logic [16*N-1:0] ncol);
      exp_t e;
      @(negedge clk);
      if (step >= 2) begin
         if (exp_q.size() == 0) begin
            check_eq("queue_underflow", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("rgb_out", 32'(rgb_out), 32'(e.rgb));
            check_eq("collide_valid", 32'(collide_valid), 32'(e.vld));
            check_eq("collide", 32'(collide), 32'(e.col));
         end
      end
      bg_color = next_bg;
      if (p_have) begin
         layer_color = p_col;
         model_push();
      end
      x          = nx;
      y          = ny;
      video_on   = nvon;
      layer_disp = ndisp;
      p_have     = 1'b1;
      p_von      = nvon;
      p_sof      = (nx == 0) && (ny == 0);
      p_disp     = ndisp;
      p_col      = ncol;
      step++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_rgb_async", 32'(rgb_out), 32'd0);
      check_eq("rst_collide_async", 32'(collide), 32'd0);
      check_eq("rst_valid_async", 32'(collide_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rgb_hold", 32'(rgb_out), 32'd0);
      check_eq("rst_collide_hold", 32'(collide), 32'd0);
      exp_q.delete();
      step      = 0;
      p_have    = 1'b0;
      m_acc     = '0;
      m_collide = '0;
      rst_n     = 1'b1;
   endtask

   function automatic logic [15:0] rnd_color();
      return ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
   endfunction

   // mode 0: one layer0/layer3 overlap, 1: empty, 2: random; reset_at < 0 disables
   task automatic play_frame(input int mode, input int reset_at);
      logic [N-1:0]    d;
      logic [16*N-1:0] c;
      int              idx;
      idx = 0;
      for (int yy = 0; yy < FH; yy++) begin
         for (int xx = 0; xx < FW; xx++) begin
            if (idx == reset_at) do_reset();
            d = '0;
            c = {N{16'hFFFF}};
            if (mode == 0 && xx == 3 && yy == 1) begin
               d = 4'b1001;
               c = {16'hABCD, 16'hFFFF, 16'hFFFF, 16'h1234};
            end else if (mode == 2) begin
               d = N'($urandom);
               for (int i = 0; i < N; i++) c[16*i +: 16] = rnd_color();
            end
            step_pixel(10'(xx), 9'(yy), (xx < FW - 2), d, c);
            idx++;
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      x           = 10'd1;
      y           = 9'd1;
      video_on    = 1'b0;
      layer_disp  = '0;
      layer_color = {N{16'hFFFF}};
      next_bg     = 16'h001F;
      bg_color    = next_bg;
      step        = 0;
      p_have      = 1'b0;
      m_acc       = '0;
      m_collide   = '0;
      do_reset();

      // background only
      for (int i = 1; i <= 4; i++) step_pixel(10'(i), 9'd1, 1'b1, 4'b0000, {N{16'hFFFF}});
      // layers 1 and 2 opaque, then layer 1 keyed out
      step_pixel(10'd5, 9'd1, 1'b1, 4'b0110, {16'hFFFF, 16'hF800, 16'h07E0, 16'hFFFF});
      step_pixel(10'd6, 9'd1, 1'b1, 4'b0110, {16'hFFFF, 16'hF800, 16'hFFFF, 16'hFFFF});
      // single-pixel black player pixel between background pixels
      for (int i = 4; i <= 6; i++)
         step_pixel(10'(i), 9'd2, 1'b1, (i == 5) ? 4'b0001 : 4'b0000,
                    {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000});
      // blanking beats opaque layers
      step_pixel(10'd7, 9'd2, 1'b0, 4'b1111, {16'h1111, 16'h2222, 16'h3333, 16'h4444});
      // transparent-valued background is still shown
      next_bg = 16'hFFFF;
      step_pixel(10'd8, 9'd2, 1'b1, 4'b0000, {N{16'hFFFF}});
      next_bg = 16'h001F;

      play_frame(0, -1);
      play_frame(1, -1);
      play_frame(1, -1);
      play_frame(0, -1);
      play_frame(1, 17);
      play_frame(1, -1);

      for (int f = 0; f < 20; f++) begin
         next_bg = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
         play_frame(2, -1);
      end
      play_frame(1, -1);
      for (int i = 0; i < 3; i++) step_pixel(10'd1, 9'd1, 1'b0, 4'b0000, {N{16'hFFFF}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
